// File: rtl/instr_fetch_decode.sv
// Instruction store plus registered fetch/decode stage for the 8-bit-instruction
// core. It sits between the PC register and the register-file/execute stage.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ld_we/ld_addr/ld_data     instruction-memory load port (out-of-range ignored)
//   lbl_we/lbl_addr/lbl_data  jump-label table load port
//   fetch, pc           request decode of imem[pc] this cycle
//   stall, flush        hold all outputs / kill the output slot (flush wins)
//   resume              clear the halted state
//   valid               outputs carry a decoded instruction
//   format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag, jmp_loc   decode
//   fault               the decoded pc was out of range
//   halted              a HALT has issued; doubles as the stage's state bit
//
// Handshake: there is no back-pressure. A fetch is accepted on a rising edge
// when fetch=1, stall=0, flush=0 and halted=0; its decode appears with valid=1
// after that edge and stays until the next accepted edge or a flush.
module instr_fetch_decode #(
  parameter int PC_W   = 16,
  parameter int DEPTH  = 256,
  parameter int LABELS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_we,
  input  logic [PC_W-1:0]           ld_addr,
  input  logic [7:0]                ld_data,
  input  logic                      lbl_we,
  input  logic [$clog2(LABELS)-1:0] lbl_addr,
  input  logic [PC_W-1:0]           lbl_data,
  input  logic                      fetch,
  input  logic [PC_W-1:0]           pc,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      resume,
  output logic                      valid,
  output logic [1:0]                format,
  output logic [3:0]                opcode,
  output logic [2:0]                reg1_i,
  output logic [2:0]                reg2_i,
  output logic [2:0]                reg_o,
  output logic [2:0]                imm,
  output logic                      imm_flag,
  output logic [PC_W-1:0]           jmp_loc,
  output logic                      fault,
  output logic                      halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(LABELS);
  localparam logic [PC_W:0]   DEPTH_X   = (PC_W+1)'(DEPTH);
  localparam logic [7:0]      HALT_BYTE = 8'hE0;
  localparam logic [LW-1:0]   M_BASE    = LW'(LABELS - 4);

  localparam logic [1:0] FMT_C = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_M = 2'b10;
  localparam logic [1:0] FMT_X = 2'b11;

  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_LIM  = 4'b0100;
  localparam logic [3:0] OP_MVB  = 4'b0101;
  localparam logic [3:0] OP_SFT  = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1110;

  // Memory stores bytes XOR'd with HALT so that a zero-initialised array
  // (the power-up state of most RAMs and simulators) reads back as HALT.
  logic [7:0]      imem_q  [DEPTH];
  logic [PC_W-1:0] label_q [LABELS];

  always_ff @(posedge clk) begin
    if (ld_we && ({1'b0, ld_addr} < DEPTH_X)) begin
      imem_q[ld_addr[AW-1:0]] <= ld_data ^ HALT_BYTE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LABELS; i++) label_q[i] <= '0;
    end else if (lbl_we) begin
      label_q[lbl_addr] <= lbl_data;
    end
  end

  // Combinational read; the fetch register samples the old byte on a
  // same-address load, giving read-before-write.
  logic       pc_in_range;
  logic [7:0] instr;
  assign pc_in_range = ({1'b0, pc} < DEPTH_X);
  assign instr       = pc_in_range ? (imem_q[pc[AW-1:0]] ^ HALT_BYTE) : HALT_BYTE;

  logic [3:0]      op;
  logic [1:0]      fmt_dec;
  logic [2:0]      r1_dec, r2_dec, ro_dec;
  logic [LW-1:0]   lbl_idx;
  logic [PC_W-1:0] lbl_rd, jmp_dec;

  assign op = instr[7:4];

  always_comb begin
    fmt_dec = FMT_M;
    r1_dec  = 3'd0;
    r2_dec  = 3'd0;
    ro_dec  = 3'd0;
    lbl_idx = M_BASE + LW'(instr[1:0]);
    case (op)
      OP_JMP, OP_LIM: begin
        fmt_dec = FMT_C;
        ro_dec  = instr[0] ? 3'd3 : 3'd2;
        lbl_idx = LW'(instr[3:0]);
      end
      OP_SFT, OP_INC: begin
        fmt_dec = FMT_I;
        r1_dec  = instr[3:1];
        r2_dec  = instr[3:1] + 3'd1;
        ro_dec  = instr[3:1];
      end
      OP_HALT: fmt_dec = FMT_X;
      OP_MVB: begin
        r1_dec = {1'b1, instr[1:0]};
        ro_dec = {1'b0, instr[3:2]};
      end
      default: begin
        r1_dec = {1'b0, instr[3:2]};
        r2_dec = {1'b0, instr[3:2]} + 3'd1;
        ro_dec = {1'b1, instr[1:0]};
      end
    endcase
    // Write-first: a label being loaded this cycle is seen by this fetch.
    lbl_rd  = (lbl_we && (lbl_addr == lbl_idx)) ? lbl_data : label_q[lbl_idx];
    jmp_dec = ((fmt_dec == FMT_C) || (fmt_dec == FMT_M)) ? lbl_rd : '0;
  end

  logic            accept;
  assign accept = fetch && !stall && !flush && !halted;

  logic            valid_d, flag_d, fault_d, halted_d;
  logic [1:0]      fmt_d;
  logic [3:0]      op_d;
  logic [2:0]      r1_d, r2_d, ro_d, imm_d;
  logic [PC_W-1:0] jmp_d;

  always_comb begin
    valid_d  = valid;
    fmt_d    = format;
    op_d     = opcode;
    r1_d     = reg1_i;
    r2_d     = reg2_i;
    ro_d     = reg_o;
    imm_d    = imm;
    flag_d   = imm_flag;
    jmp_d    = jmp_loc;
    fault_d  = fault;
    halted_d = halted;
    if (flush) begin
      valid_d = 1'b0;
      fmt_d   = '0;
      op_d    = '0;
      r1_d    = '0;
      r2_d    = '0;
      ro_d    = '0;
      imm_d   = '0;
      flag_d  = 1'b0;
      jmp_d   = '0;
      fault_d = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (accept) begin
      valid_d = 1'b1;
      fmt_d   = fmt_dec;
      op_d    = op;
      r1_d    = r1_dec;
      r2_d    = r2_dec;
      ro_d    = ro_dec;
      imm_d   = instr[3:1];
      flag_d  = instr[0];
      jmp_d   = jmp_dec;
      fault_d = !pc_in_range;
    end else begin
      valid_d = 1'b0;
    end
    // Halt tracking: a stall freezes it; a fetch that is ignored because of
    // halted never re-arms it, so resume+fetch only clears.
    if (flush || !stall) begin
      if (accept && (op == OP_HALT)) halted_d = 1'b1;
      else if (resume)               halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      format   <= '0;
      opcode   <= '0;
      reg1_i   <= '0;
      reg2_i   <= '0;
      reg_o    <= '0;
      imm      <= '0;
      imm_flag <= 1'b0;
      jmp_loc  <= '0;
      fault    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      valid    <= valid_d;
      format   <= fmt_d;
      opcode   <= op_d;
      reg1_i   <= r1_d;
      reg2_i   <= r2_d;
      reg_o    <= ro_d;
      imm      <= imm_d;
      imm_flag <= flag_d;
      jmp_loc  <= jmp_d;
      fault    <= fault_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Programmable instruction store plus registered decode stage for the pipelined 8-bit-instruction core.
- Replaces a hard-coded, combinational pc-to-instruction lookup with the following:
  - a loadable instruction memory of DEPTH bytes;
  - a loadable jump-label table;
  - a one-cycle registered fetch/decode with stall, flush and halt tracking.
- Sits between the PC register and the register-file/execute stage.

Parameters:
- PC_W, 16: width of pc and jump-location values.
- DEPTH, 256: instruction-memory entries; must be ≤ 2**PC_W.
- LABELS, 16: jump-label table entries; must be a power of two, ≥ 4.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- ld_we, input, 1: write ld_data into imem[ld_addr].
- ld_addr, input, PC_W: load address; writes with ld_addr ≥ DEPTH are ignored.
- ld_data, input, 8: instruction byte to load.
- lbl_we, input, 1: write lbl_data into label[lbl_addr].
- lbl_addr, input, log2(LABELS): label index.
- lbl_data, input, PC_W: label target.
- fetch, input, 1: request decode of pc this cycle.
- pc, input, PC_W: fetch address.
- stall, input, 1: hold all outputs.
- flush, input, 1: kill the output slot.
- resume, input, 1: clear the halted state.
- valid, output, 1: outputs hold a decoded instruction.
- format, output, 2: 00 C, 01 I, 10 M, 11 X.
- opcode, output, 4: instr[7:4].
- reg1_i, reg2_i, reg_o, output, 3 each: register indices.
- imm, output, 3: instr[3:1].
- imm_flag, output, 1: instr[0].
- jmp_loc, output, PC_W: resolved jump/branch target.
- fault, output, 1: pc was out of range.
- halted, output, 1: a HALT has issued.

Behaviour:
- Reset (async, rst=1):
  - valid, fault and halted go to 0.
  - All decode outputs go to 0.
  - All label entries go to 0.
  - imem is not reset; its simulation initial contents are 8'hE0 (HALT).
- Load ports:
  - Synchronous; both ports may write in the same cycle.
  - Loads are accepted regardless of stall/halted state.
- Fetch latency is 1 cycle. On the edge where fetch=1, stall=0, flush=0, halted=0:
  - The decode of imem[pc] is registered and valid goes to 1.
  - Outputs are stable until the next accepted edge.
- Read/write collision: fetch and ld_we to the same address in the same cycle returns the OLD byte (read-before-write).
- Priority, highest first: rst > flush > stall > fetch.
  - flush=1: valid goes to 0 next edge, even if stall=1; other outputs are don't-care but are driven 0.
  - stall=1 without flush: every output holds.
  - fetch=0, stall=0, flush=0: valid goes to 0.
- Out-of-range pc (pc ≥ DEPTH):
  - The byte is treated as 8'hE0.
  - fault goes to 1 along with valid.
  - fault clears on the next accepted fetch of an in-range pc, or on flush.
- Halt:
  - When an accepted fetch decodes opcode 1110, halted goes to 1 on the same edge.
  - Subsequent fetches are ignored and valid goes to 0 next edge.
  - resume=1 clears halted on the next edge. If resume and fetch are both 1 in one cycle, that fetch is still ignored.
- Format decode from opcode:
  - 0010 (JMP) and 0100 (LIM) → C.
  - 1001 (SFT) and 1101 (INC) → I.
  - 1110 (HALT) → X.
  - All other opcodes → M.
- Register decode:
  - C: reg_o = instr[0] ? 3 : 2; reg1_i = reg2_i = 0.
  - I: reg1_i = instr[3:1]; reg2_i = reg1_i + 1 mod 8 (7 wraps to 0); reg_o = reg1_i.
  - M with opcode 0101 (MVB): reg1_i = {1, instr[1:0]}; reg_o = {0, instr[3:2]}; reg2_i = 0.
  - M otherwise: reg1_i = {0, instr[3:2]}; reg2_i = reg1_i + 1; reg_o = {1, instr[1:0]}.
  - X: all three register indices = 0.
- jmp_loc:
  - C: label[instr[3:0] mod LABELS].
  - M: label[LABELS-4 + instr[1:0]].
  - I and X: 0.
- Label table forwarding: a label read uses the value being written in the same cycle (write-first).
- No X values on any output at any time after reset.

Test Plan:
- Load imem[0] = 8'hB6 (BEQ), load label[14] = 16'h0040, fetch pc=0 → next cycle:
  - valid=1, format=10, opcode=1011;
  - reg1_i=1, reg2_i=2, reg_o=6, jmp_loc=16'h0040.
- Load 8'h9E (SFT) at pc=5, fetch pc=5 → format=01, reg1_i=7, reg2_i=0 (wrap), reg_o=7, imm=7, imm_flag=0, jmp_loc=0.
- Load 8'h5B (MVB) and 8'h47 (LIM) at consecutive addresses, fetch both back-to-back:
  - MVB → reg1_i=7, reg_o=2, reg2_i=0.
  - LIM → format=00, reg_o=3, jmp_loc=label[7].
- Fetch with stall=1 for 3 cycles → outputs frozen. Then assert stall=1 and flush=1 together → valid=0 next edge.
- Fetch pc=DEPTH → valid=1, fault=1, opcode=1110, halted=1. Further fetches → valid=0. Pulse resume, fetch pc=0 → valid=1, fault=0.
- Assert rst asynchronously mid-stream (between edges) → valid, fault, halted and jmp_loc go to 0 immediately. imem contents are retained after reset release.
